// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage feeding the controller/datapath of the single-cycle core.
//   Owns the PC, requests one instruction at a time from a variable-latency
//   instruction memory, holds it until the execute side consumes it, and
//   applies the execute side's redirect (i_pcsrc/i_pctarget) at consume time.
//
//   Ports:
//     i_clk, i_rst             clock, asynchronous active-high reset
//     o_imem_valid/i_imem_ready, o_imem_addr
//                              request channel (address = current PC)
//     i_imem_rvalid/i_imem_rdata
//                              response channel
//     o_instr_valid/i_instr_ready, o_instr, o_pc, o_pcplus4
//                              held instruction towards execute
//     o_op, o_funct3, o_funct7b5
//                              decode fields sliced from o_instr
//     i_pcsrc, i_pctarget      redirect, sampled only when consumed
//     o_misalign               (IFETCH_MISALIGN_TRAP_EN only) sticky trap flag
//
//   Build option: define IFETCH_MISALIGN_TRAP_EN to trap on a redirect to a
//   target whose bits [1:0] are non-zero; the unit then halts until reset.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_valid,
  input  logic            i_imem_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [XLEN-1:0] o_instr,
  output logic [6:0]      o_op,
  output logic [2:0]      o_funct3,
  output logic            o_funct7b5,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcplus4,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic            o_misalign,
`endif
  input  logic            i_pcsrc,
  input  logic [XLEN-1:0] i_pctarget
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    misalign_d    = misalign_q;
`endif
    case (state_q)
      S_REQ: begin
        if (i_imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          instr_d       = i_imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_instr_ready) begin
          pc_d          = i_pcsrc ? i_pctarget : pc_q + XLEN'(4);
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (i_pcsrc && (i_pctarget[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end
`endif
        end
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      S_HALT: begin
        // Terminal until reset; pc_q keeps the offending target.
      end
`endif
      default: state_d = S_REQ;
    endcase
  end

  // State is already S_REQ during reset, so the request must be gated by
  // i_rst itself to stay low while reset is held.
  assign o_imem_valid  = (state_q == S_REQ) && !i_rst;
  assign o_imem_addr   = pc_q;
  assign o_instr_valid = instr_valid_q;
  assign o_instr       = instr_q;
  assign o_op          = instr_q[6:0];
  assign o_funct3      = instr_q[14:12];
  assign o_funct7b5    = instr_q[30];
  assign o_pc          = instr_pc_q;
  assign o_pcplus4     = instr_pc_q + XLEN'(4);
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign o_misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Scoreboard bench for instr_fetch_unit (RESET_PC = 32'h100). Expected
//   request addresses are pushed when a consume is driven and popped when the
//   DUT issues its next request; expected instruction words are pushed when a
//   memory response is driven and popped when the instruction is presented.
//   Define IFETCH_MISALIGN_TRAP_EN to exercise the misalignment trap.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imem_valid;
  logic        i_imem_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instr;
  logic [6:0]  o_op;
  logic [2:0]  o_funct3;
  logic        o_funct7b5;
  logic [31:0] o_pc;
  logic [31:0] o_pcplus4;
  logic        i_pcsrc;
  logic [31:0] i_pctarget;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always #5 i_clk = ~i_clk;

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_valid  (o_imem_valid),
    .i_imem_ready  (i_imem_ready),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_instr       (o_instr),
    .o_op          (o_op),
    .o_funct3      (o_funct3),
    .o_funct7b5    (o_funct7b5),
    .o_pc          (o_pc),
    .o_pcplus4     (o_pcplus4),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .o_misalign    (o_misalign),
`endif
    .i_pcsrc       (i_pcsrc),
    .i_pctarget    (i_pctarget)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One cycle: sample point is 1 time unit after the falling edge.
  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic pop_addr(output logic [31:0] a);
    if (exp_addr_q.size() == 0) begin
      check_eq("sb_addr_empty", 32'd0, 32'd1);
      a = 'x;
    end else a = exp_addr_q.pop_front();
  endtask

  task automatic pop_data(output logic [31:0] d);
    if (exp_data_q.size() == 0) begin
      check_eq("sb_data_empty", 32'd0, 32'd1);
      d = 'x;
    end else d = exp_data_q.pop_front();
  endtask

  // Full transaction: request (stalled 'stall' cycles), response after 'lat'
  // extra wait cycles, hold 'hold' cycles, then consume with the redirect.
  task automatic do_fetch(input logic [31:0] data, input int stall, input int lat,
                          input int hold, input logic pcsrc, input logic [31:0] tgt);
    logic [31:0] ea, ed;
    logic        trap;
    pop_addr(ea);
    check_eq("req_valid", {31'd0, o_imem_valid}, 32'd1);
    check_eq("req_addr", o_imem_addr, ea);
    for (int i = 0; i < stall; i++) begin
      // Stray response and consume while requesting must be ignored.
      i_imem_ready  = 1'b0;
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = 32'hDEAD_BEEF;
      i_instr_ready = 1'b1;
      i_pcsrc       = 1'b1;
      i_pctarget    = 32'h0000_0F00;
      step();
      check_eq("stall_valid", {31'd0, o_imem_valid}, 32'd1);
      check_eq("stall_addr", o_imem_addr, ea);
      check_eq("stall_ivalid", {31'd0, o_instr_valid}, 32'd0);
    end
    i_imem_rvalid = 1'b0;
    i_instr_ready = 1'b0;
    i_pcsrc       = 1'b0;
    i_imem_ready  = 1'b1;
    step();
    i_imem_ready  = 1'b0;
    check_eq("wait_req_low", {31'd0, o_imem_valid}, 32'd0);
    check_eq("wait_ivalid", {31'd0, o_instr_valid}, 32'd0);
    for (int i = 0; i < lat; i++) begin
      step();
      check_eq("lat_req_low", {31'd0, o_imem_valid}, 32'd0);
      check_eq("lat_ivalid", {31'd0, o_instr_valid}, 32'd0);
    end
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = data;
    exp_data_q.push_back(data);
    step();
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = $urandom;
    pop_data(ed);
    check_eq("ivalid", {31'd0, o_instr_valid}, 32'd1);
    check_eq("instr", o_instr, ed);
    check_eq("op", {25'd0, o_op}, {25'd0, ed[6:0]});
    check_eq("funct3", {29'd0, o_funct3}, {29'd0, ed[14:12]});
    check_eq("funct7b5", {31'd0, o_funct7b5}, {31'd0, ed[30]});
    check_eq("pc", o_pc, ea);
    check_eq("pcplus4", o_pcplus4, ea + 32'd4);
    for (int i = 0; i < hold; i++) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = ~data;
      i_pcsrc       = 1'b1;
      i_pctarget    = 32'h0000_0E00;
      step();
      check_eq("hold_instr", o_instr, ed);
      check_eq("hold_pc", o_pc, ea);
      check_eq("hold_ivalid", {31'd0, o_instr_valid}, 32'd1);
      check_eq("hold_req_low", {31'd0, o_imem_valid}, 32'd0);
    end
    i_imem_rvalid = 1'b0;
    i_instr_ready = 1'b1;
    i_pcsrc       = pcsrc;
    i_pctarget    = tgt;
    exp_addr_q.push_back(pcsrc ? tgt : ea + 32'd4);
    step();
    i_instr_ready = 1'b0;
    i_pcsrc       = 1'b0;
    i_pctarget    = $urandom;
`ifdef IFETCH_MISALIGN_TRAP_EN
    trap = pcsrc && (tgt[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    check_eq("consumed_ivalid", {31'd0, o_instr_valid}, 32'd0);
    check_eq("next_req", {31'd0, o_imem_valid}, {31'd0, !trap});
  endtask

  initial begin
    logic [31:0] ea;
    i_rst = 1'b1;
    i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    i_instr_ready = 1'b0; i_pcsrc = 1'b0; i_pctarget = '0;
    #2;
    check_eq("rst_ivalid", {31'd0, o_instr_valid}, 32'd0);
    check_eq("rst_instr", o_instr, 32'h0000_0013);
    check_eq("rst_req", {31'd0, o_imem_valid}, 32'd0);
    step();
    step();
    i_rst = 1'b0;
    #1;
    exp_addr_q.push_back(RST_PC);

    // addi, sub, beq redirect, backpressured sw, wrap-around
    do_fetch(32'h0050_0093, 0, 0, 0, 1'b0, 32'h0);
    do_fetch(32'h40B5_0533, 0, 0, 0, 1'b0, 32'h0);
    do_fetch(32'hFE00_0EE3, 0, 0, 0, 1'b1, 32'h0000_0200);
    do_fetch(32'h00A1_2023, 3, 2, 4, 1'b1, 32'hFFFF_FFFC);
    do_fetch(32'h0000_6033, 0, 1, 1, 1'b0, 32'h0);
    check_eq("wrap_addr", o_imem_addr, 32'h0000_0000);

`ifdef IFETCH_MISALIGN_TRAP_EN
    do_fetch(32'h0000_0063, 0, 0, 0, 1'b1, 32'h0000_0202);
    void'(exp_addr_q.pop_front());
    check_eq("misalign_set", {31'd0, o_misalign}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      i_imem_ready  = 1'b1;
      i_imem_rvalid = 1'b1;
      i_instr_ready = 1'b1;
      step();
      check_eq("halt_req_low", {31'd0, o_imem_valid}, 32'd0);
      check_eq("halt_ivalid", {31'd0, o_instr_valid}, 32'd0);
    end
    check_eq("halt_pc", o_imem_addr, 32'h0000_0202);
    i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_instr_ready = 1'b0;
    i_rst = 1'b1;
    #1;
    check_eq("misalign_clr", {31'd0, o_misalign}, 32'd0);
    step();
    i_rst = 1'b0;
    #1;
    exp_addr_q.push_back(RST_PC);
`else
    // Misaligned target is fetched as-is without the trap.
    do_fetch(32'h0000_0063, 0, 0, 0, 1'b1, 32'h0000_0202);
    do_fetch(32'h0000_0013, 0, 0, 0, 1'b0, 32'h0);
`endif

    // Reset in S_WAIT: request accepted, then reset before the response.
    pop_addr(ea);
    check_eq("pre_rst_addr", o_imem_addr, ea);
    i_imem_ready = 1'b1;
    step();
    i_imem_ready = 1'b0;
    i_rst = 1'b1;
    #1;
    check_eq("rst_wait_ivalid", {31'd0, o_instr_valid}, 32'd0);
    check_eq("rst_wait_instr", o_instr, 32'h0000_0013);
    check_eq("rst_wait_req", {31'd0, o_imem_valid}, 32'd0);
    step();
    i_rst = 1'b0;
    #1;
    exp_addr_q.push_back(RST_PC);
    do_fetch(32'h0020_8133, 0, 0, 0, 1'b0, 32'h0);
    check_eq("post_rst_next", o_imem_addr, RST_PC + 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
